// File: rtl/iob_fifo_wptr_ctrl.sv
// Write-side pointer and flag controller for an async FIFO.
// Keeps binary and Gray write pointers, and derives full/level/almost-full against a synchronized Gray read pointer.
module iob_fifo_wptr_ctrl #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned AFULL_LVL = (1 << ADDR_W) - 1
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              w_en_i,
    input  logic [ADDR_W:0]   r_gray_i,
    output logic              w_accept_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [ADDR_W:0]   w_gray_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o
);

    localparam logic [ADDR_W:0] AFULL_V = (ADDR_W + 1)'(AFULL_LVL);

    logic [ADDR_W:0] w_bin_q, w_bin_d;
    logic [ADDR_W:0] w_gray_q, w_gray_d;
    logic [ADDR_W:0] level_q, level_d;
    logic            full_q, full_d;
    logic            afull_q, afull_d;
    logic            ovf_q, ovf_d;
    logic [ADDR_W:0] w_bin_inc;
    logic [ADDR_W:0] r_bin;
    logic [ADDR_W:0] full_cmp;
    logic            accept;

    assign accept    = w_en_i & ~full_q & cke_i;
    assign w_bin_inc = w_bin_q + 1'b1;

    always_comb begin
        r_bin         = '0;
        r_bin[ADDR_W] = r_gray_i[ADDR_W];
        for (int i = int'(ADDR_W) - 1; i >= 0; i--) begin
            r_bin[i] = r_bin[i+1] ^ r_gray_i[i];
        end
    end

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    generate
        if (ADDR_W == 1) begin : g_cmp_narrow
            assign full_cmp = ~r_gray_i;
        end else begin : g_cmp_wide
            assign full_cmp = {~r_gray_i[ADDR_W:ADDR_W-1], r_gray_i[ADDR_W-2:0]};
        end
    endgenerate

    always_comb begin
        w_bin_d  = w_bin_q;
        w_gray_d = w_gray_q;
        if (accept) begin
            w_bin_d  = w_bin_inc;
            w_gray_d = w_bin_inc ^ (w_bin_inc >> 1);
        end
        level_d = w_bin_d - r_bin;
        full_d  = (w_gray_d == full_cmp);
        afull_d = (level_d >= AFULL_V);
        ovf_d   = ovf_q | (w_en_i & full_q);
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                w_bin_q  <= '0;
                w_gray_q <= '0;
                level_q  <= '0;
                full_q   <= 1'b0;
                afull_q  <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                w_bin_q  <= w_bin_d;
                w_gray_q <= w_gray_d;
                level_q  <= level_d;
                full_q   <= full_d;
                afull_q  <= afull_d;
                ovf_q    <= ovf_d;
            end
        end
    end

    assign w_accept_o    = accept;
    assign w_addr_o      = w_bin_q[ADDR_W-1:0];
    assign w_gray_o      = w_gray_q;
    assign full_o        = full_q;
    assign almost_full_o = afull_q;
    assign level_o       = level_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_iob_fifo_wptr_ctrl.sv
// Bench for iob_fifo_wptr_ctrl at ADDR_W=2, AFULL_LVL=3: vector table plus a Gray wrap sequence.
module tb_iob_fifo_wptr_ctrl;

    logic       clk = 1'b0;
    logic       cke, rst, wen;
    logic [2:0] rg;
    logic       w_accept;
    logic [1:0] w_addr;
    logic [2:0] w_gray;
    logic       full, afull, ovf;
    logic [2:0] level;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst, cke, wen;
        logic [2:0] rg;
        logic       acc;
        logic [1:0] addr;
        logic [2:0] gray;
        logic       full, af;
        logic [2:0] lvl;
        logic       ovf;
    } vec_t;

    vec_t tbl[17];
    vec_t sb[$];

    iob_fifo_wptr_ctrl #(.ADDR_W(2), .AFULL_LVL(3)) dut (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .w_en_i(wen), .r_gray_i(rg),
        .w_accept_o(w_accept), .w_addr_o(w_addr), .w_gray_o(w_gray),
        .full_o(full), .almost_full_o(afull), .level_o(level), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, c, w, input logic [2:0] g, input logic a,
                                input logic [1:0] ad, input logic [2:0] gy, input logic f, af,
                                input logic [2:0] l, input logic o);
        vec_t v;
        v.rst = r; v.cke = c; v.wen = w; v.rg = g; v.acc = a;
        v.addr = ad; v.gray = gy; v.full = f; v.af = af; v.lvl = l; v.ovf = o;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        vec_t e;
        @(negedge clk);
        rst = v.rst; cke = v.cke; wen = v.wen; rg = v.rg;
        #1;
        chk({nm, ".accept"}, int'(w_accept), int'(v.acc));
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({nm, ".addr"},  int'(w_addr), int'(e.addr));
        chk({nm, ".gray"},  int'(w_gray), int'(e.gray));
        chk({nm, ".full"},  int'(full),   int'(e.full));
        chk({nm, ".afull"}, int'(afull),  int'(e.af));
        chk({nm, ".level"}, int'(level),  int'(e.lvl));
        chk({nm, ".ovf"},   int'(ovf),    int'(e.ovf));
    endtask

    initial begin
        logic [2:0] gseq [8];
        logic [2:0] prev_gray;
        vec_t v;

        cke = 1'b1; rst = 1'b1; wen = 1'b0; rg = 3'b000;

        //                 rst  cke  wen  rg      acc  addr   gray    full af   lvl     ovf
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 2'd1, 3'b001, 1'b0, 1'b0, 3'd1, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 2'd2, 3'b011, 1'b0, 1'b0, 3'd2, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 2'd3, 3'b010, 1'b0, 1'b1, 3'd3, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 2'd0, 3'b110, 1'b1, 1'b1, 3'd4, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 1'b1, 3'd4, 1'b1);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 1'b1, 3'd4, 1'b1);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b0, 1'b1, 3'd3, 1'b1);
        tbl[9]  = mk(1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 2'd1, 3'b111, 1'b1, 1'b1, 3'd4, 1'b1);
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 2'd1, 3'b111, 1'b1, 1'b1, 3'd4, 1'b1);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 2'd1, 3'b001, 1'b0, 1'b0, 3'd1, 1'b0);
        tbl[14] = mk(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 2'd2, 3'b011, 1'b0, 1'b0, 3'd2, 1'b0);
        tbl[15] = mk(1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 2'd3, 3'b010, 1'b0, 1'b0, 3'd2, 1'b0);
        // Write and read-pointer step land in the same cycle: level holds at 2.
        tbl[16] = mk(1'b0, 1'b1, 1'b1, 3'b011, 1'b1, 2'd0, 3'b110, 1'b0, 1'b0, 3'd2, 1'b0);

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Eight writes with the reader keeping pace: Gray pointer walks the full cycle and wraps.
        gseq[0] = 3'b000; gseq[1] = 3'b001; gseq[2] = 3'b011; gseq[3] = 3'b010;
        gseq[4] = 3'b110; gseq[5] = 3'b111; gseq[6] = 3'b101; gseq[7] = 3'b100;
        apply(mk(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0), "wrap.rst");
        prev_gray = w_gray;
        for (int i = 0; i < 8; i++) begin
            v = mk(1'b0, 1'b1, 1'b1, gseq[i], 1'b1, 2'((i + 1) % 4), gseq[(i + 1) % 8],
                   1'b0, 1'b0, 3'd1, 1'b0);
            apply(v, $sformatf("wrap%0d", i));
            chk($sformatf("wrap%0d.onebit", i), $countones(prev_gray ^ w_gray), 1);
            chk($sformatf("wrap%0d.lvl_le4", i), int'(level <= 3'd4), 1);
            prev_gray = w_gray;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_fifo_wptr_ctrl.md
IOB_FIFO_WPTR_CTRL -- requirements
Module: iob_fifo_wptr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: FIFO address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
REQ-002 SHALL have parameter AFULL_LVL, default 2^ADDR_W-1: level at which almost_full_o asserts; legal range 1..2^ADDR_W.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports named clk_i, cke_i, rst_i.
REQ-004 clk_i  input  1  write-domain clock; all state on rising edge.
REQ-005 cke_i  input  1  clock enable; 0 freezes all state, including sticky flags.
REQ-006 rst_i  input  1  synchronous active-high reset; effective only when cke_i=1.
REQ-007 w_en_i  input  1  write request.
REQ-008 r_gray_i  input  ADDR_W+1  read pointer, Gray-coded, already synchronized into clk_i domain.
REQ-009 w_accept_o  output  1  write accepted this cycle; drives RAM write enable.
REQ-010 w_addr_o  output  ADDR_W  RAM write address (binary pointer LSBs).
REQ-011 w_gray_o  output  ADDR_W+1  registered Gray write pointer, for synchronization into the read domain.
REQ-012 full_o  output  1  FIFO full.
REQ-013 almost_full_o  output  1  level_o >= AFULL_LVL.
REQ-014 level_o  output  ADDR_W+1  occupancy, 0..2^ADDR_W.
REQ-015 overflow_o  output  1  sticky: write requested while full.

Function
REQ-016 SHALL hold binary write pointer w_bin (ADDR_W+1 bits) and Gray pointer w_gray as separate registers, both advanced in the same cycle.
REQ-017 w_accept_o SHALL be combinational: w_en_i & ~full_o & cke_i.
REQ-018 On accept: w_bin <= w_bin+1 (mod 2^(ADDR_W+1)); w_gray <= gray(w_bin+1), gray(x) = x ^ (x>>1); otherwise both hold.
REQ-019 w_gray_o SHALL come directly from a register (no logic after flop); exactly one bit changes per increment, including wrap from all-ones binary to zero.
REQ-020 w_addr_o SHALL equal w_bin[ADDR_W-1:0] (address of the write in progress).
REQ-021 r_bin SHALL be derived combinationally from r_gray_i by prefix XOR (r_bin[ADDR_W] = r_gray_i[ADDR_W]; r_bin[i] = r_bin[i+1] ^ r_gray_i[i]).
REQ-022 full_o SHALL be registered: next value = (w_gray_next == {~r_gray_i[ADDR_W:ADDR_W-1], r_gray_i[ADDR_W-2:0]}), with w_gray_next the post-update pointer; for ADDR_W=1 compare against ~r_gray_i[1:0].
REQ-023 level_o SHALL be registered: next value = w_bin_next - r_bin, modulo 2^(ADDR_W+1).
REQ-024 almost_full_o SHALL be registered: next value = (w_bin_next - r_bin) >= AFULL_LVL.
REQ-025 full_o/level_o/almost_full_o SHALL lag a change of r_gray_i by one cycle (conservative: may read full when not, never not-full when full).
REQ-026 A write and an r_gray_i change in the same cycle SHALL both be reflected in next-cycle flags.
REQ-027 overflow_o SHALL set when w_en_i & full_o & cke_i and stay set until rst_i; pointers SHALL not advance on a rejected write.
REQ-028 r_gray_i SHALL never be registered or resynchronized inside this block.

Reset
REQ-029 On rst_i=1 with cke_i=1: w_bin, w_gray, level_o, full_o, almost_full_o, overflow_o all 0 at next edge; w_addr_o = 0.
REQ-030 Reset SHALL take priority over a simultaneous w_en_i; w_accept_o may assert that cycle but no pointer update occurs.
REQ-031 Reset mid-operation SHALL clear state regardless of r_gray_i; flags recompute from r_gray_i on the first post-reset edge.

Verification (ADDR_W=2, AFULL_LVL=3)
REQ-032 Reset, r_gray_i=000, w_en_i=1 for 4 cycles -> w_addr_o 0,1,2,3; w_gray_o 001,011,010,110; level_o 1..4; almost_full_o=1 after 3rd write; full_o=1 after 4th.
REQ-033 Full, w_en_i=1 -> w_accept_o=0, pointers unchanged, overflow_o=1 next cycle and held after w_en_i=0.
REQ-034 Full, r_gray_i 000->001 -> one cycle later full_o=0, level_o=3; next write accepted at w_addr_o=0.
REQ-035 8 writes interleaved with reads, r_gray_i tracking -> w_gray_o 000,001,011,010,110,111,101,100,000; one bit per step; level_o never >4.
REQ-036 Write with r_gray_i change same cycle (level 2, r 001->011) -> next level_o=2.
REQ-037 cke_i=0 with w_en_i=1 -> w_accept_o=0, all outputs frozen; rst_i with cke_i=0 -> no effect.
